// File: rtl/forward_unit_if.sv
// Decode/result bundle and forwarding/stall outputs of the forwarding unit.
// The master side is the pipeline; forward_unit uses the slave side.
interface forward_unit_if;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned DATA_W = 16;

  logic              Dec_valid;
  logic              Dec_RegWrite;
  logic              Dec_MemRead;
  logic [REG_W-1:0]  Dec_Write_reg_sel;
  logic [REG_W-1:0]  Dec_Read1sel;
  logic [REG_W-1:0]  Dec_Read2sel;
  logic              Dec_Read1use;
  logic              Dec_Read2use;
  logic [DATA_W-1:0] Ex_result;
  logic [DATA_W-1:0] Mem_result;
  logic [DATA_W-1:0] Wb_result;
  logic              Flush;
  logic [11:0]       Forwarding_vector;
  logic [47:0]       Forwarding_data;
  logic              Stall;
  logic              Wb_RegWrite;
  logic [REG_W-1:0]  Wb_Write_reg_sel;

  modport master (
    output Dec_valid, Dec_RegWrite, Dec_MemRead, Dec_Write_reg_sel,
    output Dec_Read1sel, Dec_Read2sel, Dec_Read1use, Dec_Read2use,
    output Ex_result, Mem_result, Wb_result, Flush,
    input  Forwarding_vector, Forwarding_data, Stall, Wb_RegWrite, Wb_Write_reg_sel
  );

  modport slave (
    input  Dec_valid, Dec_RegWrite, Dec_MemRead, Dec_Write_reg_sel,
    input  Dec_Read1sel, Dec_Read2sel, Dec_Read1use, Dec_Read2use,
    input  Ex_result, Mem_result, Wb_result, Flush,
    output Forwarding_vector, Forwarding_data, Stall, Wb_RegWrite, Wb_Write_reg_sel
  );
endinterface

// File: rtl/forward_unit.sv
// Forwarding / hazard unit for a 5-stage pipeline with 8 registers.
// Tracks {wr, ld, reg} tags for EX, MEM and WB and reports forwarding slots
// and load-use stalls. Define FORWARD_UNIT_BYPASS_EN for the full bypass
// network; the default build has no bypass and stalls until the producer
// reaches WB (the register file handles the same-cycle write/read case).
// Forwarding outputs and Stall are combinational (zero-cycle latency).
module forward_unit (
  input  logic          clk,
  input  logic          rst,
  forward_unit_if.slave bus
);
  localparam int unsigned REG_W  = 3;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic             wr;
    logic             ld;
    logic [REG_W-1:0] rsel;
  } tag_t;

  tag_t ex_q;
  tag_t mem_q;
  tag_t wb_q;
  tag_t dec_tag_c;

  logic              hit_ex_c;
  logic              hit_mem_c;
  logic              stall_c;
  logic [11:0]       vector_c;
  logic [47:0]       data_c;
  logic              unused_bits;

  // Does the decode instruction consume the register named by EX / MEM
  always_comb begin
    hit_ex_c  = (bus.Dec_Read1use && (bus.Dec_Read1sel == ex_q.rsel)) ||
                (bus.Dec_Read2use && (bus.Dec_Read2sel == ex_q.rsel));
    hit_mem_c = (bus.Dec_Read1use && (bus.Dec_Read1sel == mem_q.rsel)) ||
                (bus.Dec_Read2use && (bus.Dec_Read2sel == mem_q.rsel));
  end

  // Tag the decode instruction carries into EX; a bubble on stall or flush
  always_comb begin
    dec_tag_c = '0;
    if (!stall_c && !bus.Flush) begin
      dec_tag_c.wr   = bus.Dec_valid & bus.Dec_RegWrite;
      dec_tag_c.ld   = bus.Dec_MemRead;
      dec_tag_c.rsel = bus.Dec_Write_reg_sel;
    end
  end

  // Tag pipeline: MEM and WB always shift, EX takes the decode tag or a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= dec_tag_c;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

`ifdef FORWARD_UNIT_BYPASS_EN
  logic ex_vld_c;
  logic mem_vld_c;
  logic wb_vld_c;

  // Forwarding slots; a load still in EX has no data yet, so it stalls instead
  always_comb begin
    ex_vld_c  = ex_q.wr & ~ex_q.ld;
    mem_vld_c = mem_q.wr;
    wb_vld_c  = wb_q.wr;
    vector_c  = {wb_vld_c, wb_q.rsel, mem_vld_c, mem_q.rsel, ex_vld_c, ex_q.rsel};
    data_c    = {wb_vld_c  ? bus.Wb_result  : DATA_W'(0),
                 mem_vld_c ? bus.Mem_result : DATA_W'(0),
                 ex_vld_c  ? bus.Ex_result  : DATA_W'(0)};
    stall_c   = ~bus.Flush & ex_q.wr & ex_q.ld & hit_ex_c;
  end

  assign unused_bits = ^{mem_q.ld, wb_q.ld, hit_mem_c};
`else
  // No bypass: hold decode while any EX/MEM producer of a consumed register is in flight
  always_comb begin
    vector_c = '0;
    data_c   = '0;
    stall_c  = ~bus.Flush & ((ex_q.wr & hit_ex_c) | (mem_q.wr & hit_mem_c));
  end

  assign unused_bits = ^{ex_q.ld, mem_q.ld, wb_q.ld,
                         bus.Ex_result, bus.Mem_result, bus.Wb_result};
`endif

  assign bus.Forwarding_vector = vector_c;
  assign bus.Forwarding_data   = data_c;
  assign bus.Stall             = stall_c;
  assign bus.Wb_RegWrite       = wb_q.wr;
  assign bus.Wb_Write_reg_sel  = wb_q.rsel;
endmodule

// File: tb/tb_forward_unit.sv
// Testbench for forward_unit: directed instruction sequences, an in-flight
// instruction queue model compared every cycle, plus literal expectations.
`timescale 1ns/1ps
module tb_forward_unit;
  logic clk = 1'b0;
  logic rst;

  forward_unit_if bus ();

  forward_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instructions in flight: [0] in EX, [1] in MEM, [2] in WB
  typedef struct {
    bit       wr;
    bit       ld;
    bit [2:0] rd;
  } ins_t;
  ins_t pipe[$];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void clear_model();
    ins_t b;
    b.wr = 1'b0; b.ld = 1'b0; b.rd = 3'd0;
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back(b);
  endfunction

  function automatic bit reads(input bit [2:0] r);
    return (bus.Dec_Read1use && bus.Dec_Read1sel == r) ||
           (bus.Dec_Read2use && bus.Dec_Read2sel == r);
  endfunction

  function automatic bit exp_stall();
    if (bus.Flush) return 1'b0;
`ifdef FORWARD_UNIT_BYPASS_EN
    return pipe[0].wr && pipe[0].ld && reads(pipe[0].rd);
`else
    return (pipe[0].wr && reads(pipe[0].rd)) || (pipe[1].wr && reads(pipe[1].rd));
`endif
  endfunction

  task automatic model_out(output logic [11:0] v, output logic [47:0] d);
`ifdef FORWARD_UNIT_BYPASS_EN
    logic [15:0] res [3];
    res[0] = bus.Ex_result;
    res[1] = bus.Mem_result;
    res[2] = bus.Wb_result;
`endif
    v = '0;
    d = '0;
`ifdef FORWARD_UNIT_BYPASS_EN
    for (int i = 0; i < 3; i++) begin
      bit ok;
      ok = pipe[i].wr && (i != 0 || !pipe[i].ld);
      v[4*i +: 4] = {ok, pipe[i].rd};
      if (ok) d[16*i +: 16] = res[i];
    end
`endif
  endtask

  // Model: the decode instruction (or a bubble) joins the front each clock
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      clear_model();
    end else begin
      ins_t nx;
      nx.wr = 1'b0; nx.ld = 1'b0; nx.rd = 3'd0;
      if (!exp_stall() && !bus.Flush) begin
        nx.wr = bus.Dec_valid && bus.Dec_RegWrite;
        nx.ld = bus.Dec_MemRead;
        nx.rd = bus.Dec_Write_reg_sel;
      end
      pipe.push_front(nx);
      void'(pipe.pop_back());
    end
  end

  // Per-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    logic [11:0] ev;
    logic [47:0] ed;
    model_out(ev, ed);
    check("cyc_vector", 48'(bus.Forwarding_vector), 48'(ev));
    check("cyc_data",   bus.Forwarding_data, ed);
    check("cyc_stall",  48'(bus.Stall), 48'(exp_stall()));
    check("cyc_wb_wr",  48'(bus.Wb_RegWrite), 48'(pipe[2].wr));
    check("cyc_wb_sel", 48'(bus.Wb_Write_reg_sel), 48'(pipe[2].rd));
  end

  task automatic dec(input bit v, input bit rw, input bit mr, input bit [2:0] wsel,
                     input bit [2:0] r1, input bit u1, input bit [2:0] r2, input bit u2);
    bus.Dec_valid         = v;
    bus.Dec_RegWrite      = rw;
    bus.Dec_MemRead       = mr;
    bus.Dec_Write_reg_sel = wsel;
    bus.Dec_Read1sel      = r1;
    bus.Dec_Read1use      = u1;
    bus.Dec_Read2sel      = r2;
    bus.Dec_Read2use      = u2;
  endtask

  task automatic bubble();
    dec(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bubble();
    bus.Flush = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear_model();
    rst = 1'b1;
    bubble();
    bus.Flush      = 1'b0;
    bus.Ex_result  = 16'hAAAA;
    bus.Mem_result = 16'hBBBB;
    bus.Wb_result  = 16'hCCCC;
    #12;
    check("rst_vector", 48'(bus.Forwarding_vector), 48'h0);
    check("rst_data",   bus.Forwarding_data, 48'h0);
    check("rst_stall",  48'(bus.Stall), 48'h0);
    check("rst_wb_wr",  48'(bus.Wb_RegWrite), 48'h0);
    rst = 1'b0;

    // ADD r3 then a read of r3
    dec(1'b1, 1'b1, 1'b0, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0);
    step();
    dec(1'b1, 1'b0, 1'b0, 3'd0, 3'd3, 1'b1, 3'd0, 1'b0);
    bus.Ex_result = 16'h1234;
    #1;
`ifdef FORWARD_UNIT_BYPASS_EN
    check("alu_vec_ex",  48'(bus.Forwarding_vector[3:0]), 48'hB);
    check("alu_data_ex", 48'(bus.Forwarding_data[15:0]), 48'h1234);
    check("alu_stall",   48'(bus.Stall), 48'h0);
`else
    check("nb_stall1", 48'(bus.Stall), 48'h1);
    check("nb_vector", 48'(bus.Forwarding_vector), 48'h0);
    step(); #1;
    check("nb_stall2", 48'(bus.Stall), 48'h1);
    check("nb_vector2", 48'(bus.Forwarding_vector), 48'h0);
    step(); #1;
    check("nb_stall3", 48'(bus.Stall), 48'h0);
`endif
    drain();

    // Register 0 behaves like any other register
    dec(1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    step();
    dec(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1);
    bus.Ex_result = 16'h00F0;
    #1;
`ifdef FORWARD_UNIT_BYPASS_EN
    check("r0_vec_ex",  48'(bus.Forwarding_vector[3:0]), 48'h8);
    check("r0_data_ex", 48'(bus.Forwarding_data[15:0]), 48'h00F0);
    check("r0_stall",   48'(bus.Stall), 48'h0);
`else
    check("r0_stall",   48'(bus.Stall), 48'h1);
`endif
    drain();

    // Load-use: LD r2 then a read of r2
    dec(1'b1, 1'b1, 1'b1, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0);
    step();
    dec(1'b1, 1'b1, 1'b0, 3'd6, 3'd0, 1'b0, 3'd2, 1'b1);
    bus.Mem_result = 16'hBEEF;
    #1;
    check("lu_stall1", 48'(bus.Stall), 48'h1);
    step(); #1;
`ifdef FORWARD_UNIT_BYPASS_EN
    check("lu_stall2",    48'(bus.Stall), 48'h0);
    check("lu_vec_mem",   48'(bus.Forwarding_vector[7:4]), 48'hA);
    check("lu_data_mem",  48'(bus.Forwarding_data[31:16]), 48'hBEEF);
    check("lu_ex_bubble", 48'(bus.Forwarding_vector[3:0]), 48'h0);
`else
    check("lu_stall2", 48'(bus.Stall), 48'h1);
    step(); #1;
    check("lu_stall3", 48'(bus.Stall), 48'h0);
`endif
    drain();

    // Flush wins over a load-use hazard
    dec(1'b1, 1'b1, 1'b1, 3'd4, 3'd0, 1'b0, 3'd0, 1'b0);
    step();
    dec(1'b1, 1'b1, 1'b0, 3'd6, 3'd4, 1'b1, 3'd0, 1'b0);
    bus.Flush = 1'b1;
    #1;
    check("fl_stall", 48'(bus.Stall), 48'h0);
    step();
    bubble();
    bus.Flush = 1'b0;
    #1;
`ifdef FORWARD_UNIT_BYPASS_EN
    check("fl_ex_bubble", 48'(bus.Forwarding_vector[3:0]), 48'h0);
    check("fl_mem_ld",    48'(bus.Forwarding_vector[7:4]), 48'hC);
`endif
    step(); #1;
    check("fl_wb_ld_wr",  48'(bus.Wb_RegWrite), 48'h1);
    check("fl_wb_ld_sel", 48'(bus.Wb_Write_reg_sel), 48'h4);
    step(); #1;
    check("fl_wb_bubble", 48'(bus.Wb_RegWrite), 48'h0);
    drain();

    // r5 written in EX, MEM and WB at once
    dec(1'b1, 1'b1, 1'b0, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0);
    repeat (3) step();
    bubble();
    bus.Ex_result  = 16'h1111;
    bus.Mem_result = 16'h2222;
    bus.Wb_result  = 16'h3333;
    #1;
`ifdef FORWARD_UNIT_BYPASS_EN
    check("r5_vector", 48'(bus.Forwarding_vector), 48'hDDD);
    check("r5_data",   bus.Forwarding_data, 48'h3333_2222_1111);
`else
    check("r5_vector", 48'(bus.Forwarding_vector), 48'h0);
    check("r5_data",   bus.Forwarding_data, 48'h0);
`endif
    check("r5_wb_wr",  48'(bus.Wb_RegWrite), 48'h1);
    check("r5_wb_sel", 48'(bus.Wb_Write_reg_sel), 48'h5);
    drain();

    // Reset asserted between edges while a stall is pending
    dec(1'b1, 1'b1, 1'b1, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0);
    step();
    dec(1'b1, 1'b1, 1'b0, 3'd7, 3'd1, 1'b1, 3'd0, 1'b0);
    #1;
    check("rs_stall_pre", 48'(bus.Stall), 48'h1);
    #1 rst = 1'b1;
    #1;
    check("rs_stall",  48'(bus.Stall), 48'h0);
    check("rs_vector", 48'(bus.Forwarding_vector), 48'h0);
    check("rs_data",   bus.Forwarding_data, 48'h0);
    check("rs_wb_wr",  48'(bus.Wb_RegWrite), 48'h0);
    #2 rst = 1'b0;
    step();
    dec(1'b0, 1'b0, 1'b0, 3'd0, 3'd7, 1'b1, 3'd0, 1'b0);
    #1;
`ifdef FORWARD_UNIT_BYPASS_EN
    check("rs_ex_entered", 48'(bus.Forwarding_vector[3:0]), 48'hF);
    check("rs_stall_post", 48'(bus.Stall), 48'h0);
`else
    check("rs_stall_post", 48'(bus.Stall), 48'h1);
`endif
    bubble();
    step();
    step(); #1;
    check("rs_wb_wr_post",  48'(bus.Wb_RegWrite), 48'h1);
    check("rs_wb_sel_post", 48'(bus.Wb_Write_reg_sel), 48'h7);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/forward_unit.md
FORWARD_UNIT -- requirements
Module: forward_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port Dec_valid, input, 1 bit: the decode-stage instruction is real (not a bubble).
REQ-004 SHALL have ports Dec_RegWrite and Dec_MemRead, input, 1 bit each: the decode instruction writes a register, and the decode instruction is a load.
REQ-005 SHALL have port Dec_Write_reg_sel, input, 3 bits: destination register of the decode instruction.
REQ-006 SHALL have ports Dec_Read1sel and Dec_Read2sel, input, 3 bits each: source registers being read in decode.
REQ-007 SHALL have ports Dec_Read1use and Dec_Read2use, input, 1 bit each: the matching source register is actually consumed.
REQ-008 SHALL have ports Ex_result, Mem_result and Wb_result, input, 16 bits each: results of the EX, MEM and WB stages.
REQ-009 SHALL have port Flush, input, 1 bit: a taken branch or jump resolved in EX kills the decode instruction.
REQ-010 SHALL have port Forwarding_vector, output, 12 bits, as three slots {valid, reg[2:0]}:
- [3:0] = EX slot, highest priority
- [7:4] = MEM slot
- [11:8] = WB slot
REQ-011 SHALL have port Forwarding_data, output, 48 bits: [15:0], [31:16] and [47:32] carry the EX, MEM and WB slot data respectively.
REQ-012 SHALL have port Stall, output, 1 bit: hold the PC and the decode stage this cycle.
REQ-013 SHALL have ports Wb_RegWrite (output, 1 bit) and Wb_Write_reg_sel (output, 3 bits): register-file write enable and address for the WB-stage instruction.

Function
REQ-014 SHALL hold three tag registers, EX, MEM and WB, each holding {wr, ld, reg[2:0]}.
REQ-015 On each clock edge, SHALL shift MEM<=EX and WB<=MEM unconditionally.
REQ-016 On each clock edge, SHALL load EX<={Dec_valid & Dec_RegWrite, Dec_MemRead, Dec_Write_reg_sel} when neither Stall nor Flush is asserted, and load EX<=bubble (all zero) otherwise.
REQ-017 SHALL define slot valid as follows:
- EX slot valid = EX.wr & ~EX.ld
- MEM slot valid = MEM.wr
- WB slot valid = WB.wr
REQ-018 SHALL drive each slot's data field from its stage result when the slot is valid, and 16'h0000 otherwise.
REQ-019 SHALL drive the vector and data outputs combinationally from the tag registers and the result inputs, with zero-cycle latency.
REQ-020 SHALL assert Stall = ~Flush & EX.wr & EX.ld & ((Dec_Read1use & Dec_Read1sel==EX.reg) | (Dec_Read2use & Dec_Read2sel==EX.reg)), covering the load-use hazard.
REQ-021 A load-use stall SHALL last exactly one cycle: after the bubble is inserted, the load sits in MEM and forwards Mem_result.
REQ-022 When Flush and a hazard occur in the same cycle, Flush SHALL win: Stall=0 and EX<=bubble.
REQ-023 SHALL drive Wb_RegWrite=WB.wr and Wb_Write_reg_sel=WB.reg.
REQ-024 SHALL treat register 0 as an ordinary register, with no special case.
REQ-025 When two slots carry the same reg, SHALL still report both; priority resolution is done by the consumer (EX first, then MEM, then WB).

Reset
REQ-026 While rst=1, SHALL clear all tag registers immediately, without waiting for a clock.
REQ-027 While rst=1, SHALL hold Forwarding_vector=12'h000, Forwarding_data=48'h0, Stall=0 and Wb_RegWrite=0.
REQ-028 A reset during a stall SHALL discard the stall; the first cycle after reset SHALL accept the decode instruction.

Configuration
REQ-029 With macro FORWARD_UNIT_BYPASS_EN defined, SHALL provide full forwarding as specified by REQ-016 through REQ-021.
REQ-030 Without FORWARD_UNIT_BYPASS_EN, SHALL tie Forwarding_vector and Forwarding_data to zero.
REQ-031 Without FORWARD_UNIT_BYPASS_EN, SHALL assert Stall = ~Flush & (the decode instruction reads a used register that matches EX.reg with EX.wr, or MEM.reg with MEM.wr).
REQ-032 Without FORWARD_UNIT_BYPASS_EN, SHALL not stall on a WB match, because the register file bypasses same-cycle write/read.

Verification
REQ-033 SHALL cover back-to-back ALU ops: ADD r3 followed by a read of r3, Ex_result=16'h1234 -> vector[3:0]=4'hB, data[15:0]=16'h1234, Stall=0.
REQ-034 SHALL cover load-use: LD r2 followed by a read of r2 -> Stall=1 for one cycle, then vector[7:4]=4'hA with data[31:16]=Mem_result, Stall=0.
REQ-035 SHALL cover Flush during a load-use hazard -> Stall=0, and the EX tag is a bubble on the next cycle.
REQ-036 SHALL cover r5 written in EX, MEM and WB at the same time -> vector=12'hDDD, with all three data fields populated.
REQ-037 SHALL cover rst asserted mid-stall, between clock edges -> all outputs read zero immediately, and the next instruction enters EX.
REQ-038 SHALL cover operation without FORWARD_UNIT_BYPASS_EN: ADD r1 then a read of r1 -> Stall=1 for two cycles and vector stays 0.
